slice_cfg_loader: RTL and testbench

- Sits directly upstream of the slice address decoder.
- Accepts a burst-write command (start address, word count) and a data-beat stream over valid/ready handshakes.
- Issues one registered write strobe per accepted beat, with an incrementing 9-bit slice address and its data word, to the decoder and slice storage.
- Range-checks each command against the slice memory map before any write is issued:
  - synapse matrix: 0–255
  - param0..param31: 256–383, 4 words each
  - spike_out: 384

---
 rtl/slice_pkg.sv | 38 +++
 rtl/slice_cfg_loader.sv | 128 ++++++++++++
 tb/tb_slice_cfg_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slice_pkg.sv
// slice_pkg: constants and helpers for the neuromorphic slice memory map.
//   Memory map (9-bit slice address space):
//     synapse matrix : SYN_BASE   .. PARAM_BASE-1   (0..255)
//     param0..31     : PARAM_BASE .. SPIKE_ADDR-1   (256..383, PARAM_WORDS each)
//     spike_out      : SPIKE_ADDR                   (384)
//   Also provides the loader state enum and a reusable burst range check
//   that any master writing into the slice can call.
package slice_pkg;

  localparam int SLICE_ADDR_W = 9;
  localparam int LAST_ADDR    = 384;

  localparam int SYN_BASE     = 0;
  localparam int PARAM_BASE   = 256;
  localparam int PARAM_WORDS  = 4;
  localparam int SPIKE_ADDR   = 384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } loader_state_e;

  // True when every word of a burst [addr, addr+len-1] lies at or below
  // 'last'. The end address is formed one bit wider than the address so a
  // burst running past the top of the 9-bit space cannot wrap into range.
  // Callers handle len==0 separately; it is not a legal burst here.
  function automatic logic range_ok(
    input logic [SLICE_ADDR_W-1:0] addr,
    input logic [SLICE_ADDR_W-1:0] len,
    input logic [SLICE_ADDR_W:0]   last
  );
    logic [SLICE_ADDR_W:0] end_addr;
    end_addr = {1'b0, addr} + {1'b0, len} - (SLICE_ADDR_W+1)'(1);
    return (end_addr <= last);
  endfunction

endpackage

// File: rtl/slice_cfg_loader.sv
// slice_cfg_loader: burst-write front end for the slice address decoder.
//   Accepts a (start address, length) command and a stream of data beats,
//   range-checks the command against the slice memory map, then issues one
//   registered write strobe per accepted beat with an incrementing address.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   cmd_valid_i   command valid
//   cmd_ready_o   command ready (high only in IDLE)
//   cmd_addr_i    burst start address
//   cmd_len_i     burst length in words (0..511)
//   data_valid_i  data beat valid
//   data_ready_o  data beat ready (BURST and no abort)
//   data_i        data beat
//   abort_i       abandon the current burst (ignored outside BURST)
//   addr_o        write address to decoder; holds when en_o is low
//   en_o          one-cycle write strobe per accepted beat
//   wdata_o       write data; holds when en_o is low
//   done_o        one-cycle pulse on burst completion (or zero-length command)
//   err_o         one-cycle pulse when a command is rejected by the range check
module slice_cfg_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int LAST_ADDR = 384
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              en_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              done_o,
  output logic              err_o
);

  import slice_pkg::*;

  localparam logic [ADDR_W:0] LAST_EXT = (ADDR_W+1)'(LAST_ADDR);

  loader_state_e     state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;

  logic cmd_fire;
  logic data_fire;
  logic last_beat;

  // Ready signals decode straight from the state register; data_ready_o also
  // drops combinationally on abort so the aborting cycle never takes a beat.
  assign cmd_ready_o  = (state == IDLE);
  assign data_ready_o = (state == BURST) && !abort_i;

  assign cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign data_fire = data_valid_i && data_ready_o;
  assign last_beat = (remaining == ADDR_W'(1));

  // NOTE: all state and registered outputs are updated with non-blocking
  // assignments so every read in this block sees the pre-edge value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      addr_o    <= '0;
      wdata_o   <= '0;
      en_o      <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them for one cycle.
      en_o   <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_len_i == '0) begin
              done_o <= 1'b1;
            end else if (!range_ok(cmd_addr_i, cmd_len_i, LAST_EXT)) begin
              err_o <= 1'b1;
            end else begin
              cur_addr  <= cmd_addr_i;
              remaining <= cmd_len_i;
              state     <= BURST;
            end
          end
        end

        BURST: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (data_fire) begin
            en_o      <= 1'b1;
            addr_o    <= cur_addr;
            wdata_o   <= data_i;
            remaining <= remaining - ADDR_W'(1);
            if (last_beat) begin
              // Leave cur_addr on the final word so it never steps past
              // the top of the map; done_o lines up with the last en_o.
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_cfg_loader.sv
// Self-checking bench for slice_cfg_loader. Stimulus tasks push the expected
// write/done/err events into a scoreboard queue; an independent monitor pops
// and compares whenever the DUT raises en_o, done_o or err_o.
module tb_slice_cfg_loader;

  typedef enum logic [1:0] {EV_WRITE, EV_DONE, EV_ERR} ev_kind_e;
  typedef enum logic [1:0] {OUT_BURST, OUT_DONE, OUT_ERR} cmd_out_e;

  typedef struct {
    ev_kind_e    kind;
    logic [8:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data;
  logic        abort;
  logic [8:0]  addr;
  logic        en;
  logic [31:0] wdata;
  logic        done;
  logic        err;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  slice_cfg_loader #(
    .DATA_W    (32),
    .ADDR_W    (9),
    .LAST_ADDR (384)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .data_i       (data),
    .abort_i      (abort),
    .addr_o       (addr),
    .en_o         (en),
    .wdata_o      (wdata),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [8:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: one event kind at a time, write first so a final write and its
  // coincident done pop in the order the stimulus pushed them.
  task automatic expect_ev(input ev_kind_e k, input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: unexpected event addr=%0d data=0x%0h at %0t", name, addr, wdata, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k) begin
        n_errors++;
        $display("FAIL %s: got event kind %0d expected kind %0d at %0t", name, k, e.kind, $time);
      end else if (k == EV_WRITE) begin
        check("write_addr", {23'd0, addr}, {23'd0, e.addr});
        check("write_data", wdata, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (en)   expect_ev(EV_WRITE, "write_event");
        if (done) expect_ev(EV_DONE,  "done_event");
        if (err)  expect_ev(EV_ERR,   "err_event");
      end
    end
  end

  // Issue one command; 'out' is the hand-computed outcome.
  task automatic send_cmd(input logic [8:0] a, input logic [8:0] l, input cmd_out_e out);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    if (out == OUT_DONE) push_ev(EV_DONE, '0, '0);
    if (out == OUT_ERR)  push_ev(EV_ERR,  '0, '0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Present one beat; ea is the expected write address, last marks the final
  // beat of the burst, ab raises abort alongside the beat.
  task automatic send_beat(input logic [31:0] d, input logic [8:0] ea, input bit last, input bit ab);
    @(negedge clk);
    data_valid = 1'b1;
    data       = d;
    abort      = ab;
    #1;
    if (ab) begin
      check("ready_low_on_abort", {31'd0, data_ready}, 32'd0);
    end else begin
      check("data_ready", {31'd0, data_ready}, 32'd1);
      push_ev(EV_WRITE, ea, d);
      if (last) push_ev(EV_DONE, '0, '0);
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},         {31'd0, en},         32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_err"},        {31'd0, err},        32'd0);
    check({tag, "_addr"},       {23'd0, addr},       32'd0);
    check({tag, "_wdata"},      wdata,               32'd0);
    check({tag, "_cmd_ready"},  {31'd0, cmd_ready},  32'd1);
    check({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    data_valid = 1'b0;
    data       = '0;
    abort      = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 4-word burst from 0, continuous beats; done with the 4th write.
    send_cmd(9'd0, 9'd4, OUT_BURST);
    send_beat(32'hA0, 9'd0, 1'b0, 1'b0);
    send_beat(32'hA1, 9'd1, 1'b0, 1'b0);
    send_beat(32'hA2, 9'd2, 1'b0, 1'b0);
    send_beat(32'hA3, 9'd3, 1'b1, 1'b0);
    @(negedge clk);
    check("done_state_cmd_ready", {31'd0, cmd_ready}, 32'd0);

    // 380..384 with a 2-cycle valid gap after the second beat.
    send_cmd(9'd380, 9'd5, OUT_BURST);
    send_beat(32'h1380, 9'd380, 1'b0, 1'b0);
    send_beat(32'h1381, 9'd381, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(32'h1382, 9'd382, 1'b0, 1'b0);
    send_beat(32'h1383, 9'd383, 1'b0, 1'b0);
    send_beat(32'h1384, 9'd384, 1'b1, 1'b0);

    // 383+3-1 = 385 > 384: rejected.
    send_cmd(9'd383, 9'd3, OUT_ERR);
    @(negedge clk);
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Zero length: done pulse only.
    send_cmd(9'd100, 9'd0, OUT_DONE);
    @(negedge clk);
    check("zero_len_done", {31'd0, done}, 32'd1);
    check("zero_len_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Single word at the very top of the map is legal; one past is not.
    send_cmd(9'd384, 9'd1, OUT_BURST);
    send_beat(32'hFACE, 9'd384, 1'b1, 1'b0);
    send_cmd(9'd385, 9'd1, OUT_ERR);
    send_cmd(9'd511, 9'd511, OUT_ERR);

    // Abort with beat 3: two writes, no done, back in IDLE.
    send_cmd(9'd256, 9'd8, OUT_BURST);
    send_beat(32'hD0, 9'd256, 1'b0, 1'b0);
    send_beat(32'hD1, 9'd257, 1'b0, 1'b0);
    send_beat(32'hD2, 9'd0,   1'b0, 1'b1);
    @(negedge clk);
    check("abort_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_no_en", {31'd0, en}, 32'd0);

    // Asynchronous reset mid-burst, while the last write is still on en_o.
    send_cmd(9'd10, 9'd6, OUT_BURST);
    send_beat(32'hB0, 9'd10, 1'b0, 1'b0);
    send_beat(32'hB1, 9'd11, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1;

    send_cmd(9'd0, 9'd1, OUT_BURST);
    send_beat(32'hC0, 9'd0, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
